// File: rtl/gshare_predictor.sv
// Gshare conditional-branch direction predictor: a PHT of saturating counters indexed by PC XOR global history,
// with speculative history update at predict time, checkpoint recovery on mispredict, and a mispredict counter.
module gshare_predictor #(
  parameter int PHT_INDEX_BITS = 6,
  parameter int GHR_BITS       = 6,
  parameter int CTR_BITS       = 2,
  parameter int CTR_INIT       = 1,
  parameter int PC_LSB         = 2,
  parameter int PERF_BITS      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      lookup_valid,
  input  logic [31:0]               lookup_pc,
  input  logic                      lookup_is_cond,
  input  logic                      lookup_is_uncond,
  output logic                      pred_taken,
  output logic [PHT_INDEX_BITS-1:0] pred_index,
  output logic [GHR_BITS-1:0]       pred_ghr,
  input  logic                      update_valid,
  input  logic [PHT_INDEX_BITS-1:0] update_index,
  input  logic [GHR_BITS-1:0]       update_ghr,
  input  logic                      update_taken,
  input  logic                      update_mispredict,
  output logic [PERF_BITS-1:0]      mispredict_count
);

  localparam int PHT_ENTRIES = 1 << PHT_INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_INIT[CTR_BITS-1:0];
  localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;

  logic [CTR_BITS-1:0]       r_pht [PHT_ENTRIES];
  logic [GHR_BITS-1:0]       r_ghr;
  logic [PERF_BITS-1:0]      r_mispredict_count;

  logic [PHT_INDEX_BITS-1:0] w_ghr_ext;
  logic [PHT_INDEX_BITS-1:0] w_index;
  logic                      w_pred_taken;
  logic                      w_spec_shift;
  logic                      w_recover;
  logic                      w_unused_pc;

  // Shift-by-one then drop the new bit in; also correct for a 1-bit history.
  function automatic logic [GHR_BITS-1:0] ghr_push(input logic [GHR_BITS-1:0] ghr,
                                                   input logic bit_in);
    logic [GHR_BITS-1:0] res;
    res    = ghr << 1;
    res[0] = bit_in;
    return res;
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] ctr,
                                                   input logic taken);
    if (taken) return (ctr == CTR_MAX) ? ctr : ctr + 1'b1;
    else       return (ctr == '0)      ? ctr : ctr - 1'b1;
  endfunction

  always_comb begin
    w_ghr_ext                 = '0;
    w_ghr_ext[GHR_BITS-1:0]   = r_ghr;
  end

  assign w_index      = lookup_pc[PC_LSB +: PHT_INDEX_BITS] ^ w_ghr_ext;
  // Lookup reads the pre-update counter; a same-cycle write to this entry is not bypassed.
  assign w_pred_taken = lookup_is_uncond | r_pht[w_index][CTR_BITS-1];
  assign w_spec_shift = lookup_valid & lookup_is_cond & ~lookup_is_uncond;
  assign w_recover    = update_valid & update_mispredict;
  assign w_unused_pc  = ^lookup_pc;

  assign pred_taken       = w_pred_taken;
  assign pred_index       = w_index;
  assign pred_ghr         = r_ghr;
  assign mispredict_count = r_mispredict_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= CTR_RESET;
    end else if (update_valid) begin
      r_pht[update_index] <= ctr_next(r_pht[update_index], update_taken);
    end
  end

  // Recovery wins over the speculative shift: the younger lookup is squashed upstream.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ghr <= '0;
    end else if (w_recover) begin
      r_ghr <= ghr_push(update_ghr, update_taken);
    end else if (w_spec_shift) begin
      r_ghr <= ghr_push(r_ghr, w_pred_taken);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mispredict_count <= '0;
    end else if (w_recover && (r_mispredict_count != '1)) begin
      r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: table-driven vectors through a scoreboard queue,
// plus hand-written async-reset and counter-saturation sequences.
module tb_gshare_predictor;

  logic        clock;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_is_cond;
  logic        lookup_is_uncond;
  logic        pred_taken;
  logic [5:0]  pred_index;
  logic [5:0]  pred_ghr;
  logic        update_valid;
  logic [5:0]  update_index;
  logic [5:0]  update_ghr;
  logic        update_taken;
  logic        update_mispredict;
  logic [15:0] mispredict_count;

  gshare_predictor dut (
    .clock            (clock),
    .reset            (reset),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .lookup_is_cond   (lookup_is_cond),
    .lookup_is_uncond (lookup_is_uncond),
    .pred_taken       (pred_taken),
    .pred_index       (pred_index),
    .pred_ghr         (pred_ghr),
    .update_valid     (update_valid),
    .update_index     (update_index),
    .update_ghr       (update_ghr),
    .update_taken     (update_taken),
    .update_mispredict(update_mispredict),
    .mispredict_count (mispredict_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        cond;
    logic        uncond;
    logic [31:0] pc;
    logic        up_v;
    logic [5:0]  up_idx;
    logic [5:0]  up_ghr;
    logic        up_t;
    logic        up_m;
    logic        e_taken;
    logic [5:0]  e_idx;
    logic [5:0]  e_ghr;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    int          id;
    logic        taken;
    logic [5:0]  idx;
    logic [5:0]  ghr;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs are combinational on current state, so each expectation is consumed mid-cycle.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk($sformatf("v%0d pred_taken", e.id), {31'd0, pred_taken}, {31'd0, e.taken});
      chk($sformatf("v%0d pred_index", e.id), {26'd0, pred_index}, {26'd0, e.idx});
      chk($sformatf("v%0d pred_ghr", e.id), {26'd0, pred_ghr}, {26'd0, e.ghr});
      chk($sformatf("v%0d mispredict_count", e.id), {16'd0, mispredict_count}, {16'd0, e.cnt});
    end
  end

  task automatic idle_inputs();
    lookup_valid      = 1'b0;
    lookup_pc         = 32'h0;
    lookup_is_cond    = 1'b0;
    lookup_is_uncond  = 1'b0;
    update_valid      = 1'b0;
    update_index      = 6'h0;
    update_ghr        = 6'h0;
    update_taken      = 1'b0;
    update_mispredict = 1'b0;
  endtask

  initial begin
    //           cond uncond pc            upv idx    ghr    t     m      taken idx    ghr    cnt
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b1, 1'b0, 1'b0, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b1, 1'b0, 1'b1, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b1, 1'b0, 1'b1, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b1, 1'b0, 1'b1, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b0, 1'b0, 1'b1, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b0, 1'b0, 1'b1, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b0, 1'b0, 1'b0, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b0, 1'b0, 1'b0, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b0, 6'h09, 6'h00, 1'b0, 1'b0, 1'b0, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b1, 1'b0, 1'b0, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b1, 1'b0, 1'b0, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b1, 6'h09, 6'h00, 1'b1, 1'b0, 1'b1, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b1, 1'b0, 32'h124, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 6'h09, 6'h00, 16'd0});
    vecs.push_back('{1'b1, 1'b0, 32'h100, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 6'h01, 6'h01, 16'd0});
    vecs.push_back('{1'b0, 1'b1, 32'h200, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 6'h02, 6'h02, 16'd0});
    vecs.push_back('{1'b1, 1'b1, 32'h200, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 6'h02, 6'h02, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h124, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 6'h0B, 6'h02, 16'd0});
    vecs.push_back('{1'b1, 1'b0, 32'h02C, 1'b1, 6'h3F, 6'h2A, 1'b1, 1'b1, 1'b1, 6'h09, 6'h02, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 32'h000, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 6'h15, 6'h15, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 32'h000, 1'b0, 6'h3F, 6'h3F, 1'b1, 1'b1, 1'b0, 6'h15, 6'h15, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 32'h0A8, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 6'h3F, 6'h15, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 32'h0A8, 1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b1, 6'h3F, 6'h15, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 32'h0A8, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 6'h3F, 6'h15, 16'd1});

    idle_inputs();
    reset = 1'b0;
    lookup_valid   = 1'b1;
    lookup_is_cond = 1'b1;
    lookup_pc      = 32'h124;
    #12;
    chk("reset pred_ghr", {26'd0, pred_ghr}, 32'h0);
    chk("reset mispredict_count", {16'd0, mispredict_count}, 32'h0);
    chk("reset pred_index", {26'd0, pred_index}, 32'h09);
    chk("reset pred_taken", {31'd0, pred_taken}, 32'h0);
    idle_inputs();
    #1 reset = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clock);
      #1;
      lookup_valid      = 1'b1;
      lookup_is_cond    = vecs[i].cond;
      lookup_is_uncond  = vecs[i].uncond;
      lookup_pc         = vecs[i].pc;
      update_valid      = vecs[i].up_v;
      update_index      = vecs[i].up_idx;
      update_ghr        = vecs[i].up_ghr;
      update_taken      = vecs[i].up_t;
      update_mispredict = vecs[i].up_m;
      sb_q.push_back('{i, vecs[i].e_taken, vecs[i].e_idx, vecs[i].e_ghr, vecs[i].e_cnt});
      @(negedge clock);
      #1;
    end
    chk("scoreboard drained", sb_q.size(), 32'd0);

    // Asynchronous reset mid-cycle after training: takes effect without a clock edge.
    @(posedge clock);
    idle_inputs();
    #3 reset = 1'b0;
    #1;
    chk("async reset mispredict_count", {16'd0, mispredict_count}, 32'h0);
    chk("async reset pred_ghr", {26'd0, pred_ghr}, 32'h0);
    lookup_valid   = 1'b1;
    lookup_is_cond = 1'b1;
    lookup_pc      = 32'h124;
    #1;
    chk("async reset pred_index", {26'd0, pred_index}, 32'h09);
    chk("async reset pred_taken", {31'd0, pred_taken}, 32'h0);
    idle_inputs();
    @(negedge clock);
    #2 reset = 1'b1;

    // Mispredict counter saturates at all-ones.
    @(posedge clock);
    #1;
    update_valid      = 1'b1;
    update_mispredict = 1'b1;
    repeat (65534) @(posedge clock);
    #1;
    chk("perf count 0xFFFE", {16'd0, mispredict_count}, 32'hFFFE);
    @(posedge clock);
    #1;
    chk("perf count reaches 0xFFFF", {16'd0, mispredict_count}, 32'hFFFF);
    repeat (3) @(posedge clock);
    #1;
    chk("perf count holds 0xFFFF", {16'd0, mispredict_count}, 32'hFFFF);
    idle_inputs();

    @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised gshare conditional-branch direction predictor for the fetch stage. Index = PC bits XOR global history.
- PHT of saturating N-bit counters (not 1-bit), speculative GHR update at predict time, and GHR checkpoint/recovery on mispredict.
- Resolution arrives from the execute/retire side with the index and GHR checkpoint captured at predict time; also keeps a mispredict performance counter.

Parameters:
- PHT_INDEX_BITS, 6, log2 PHT entries (2^PHT_INDEX_BITS counters).
- GHR_BITS, 6, global history length; must satisfy 1 <= GHR_BITS <= PHT_INDEX_BITS.
- CTR_BITS, 2, saturating counter width (>= 1).
- CTR_INIT, 1, reset value of every counter (default = weakly not-taken).
- PC_LSB, 2, lowest PC bit used in the index.
- PERF_BITS, 16, width of mispredict counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- lookup_valid  in  1  fetch presents a branch this cycle
- lookup_pc  in  32  PC of branch
- lookup_is_cond  in  1  conditional branch (BEQ/BNE/BLT/BLE/BGT/BGE/BLBC/BLBS)
- lookup_is_uncond  in  1  BR/BSR
- pred_taken  out  1  predicted direction
- pred_index  out  PHT_INDEX_BITS  PHT index used; carried with the branch
- pred_ghr  out  GHR_BITS  GHR before this prediction (checkpoint)
- update_valid  in  1  branch resolved this cycle
- update_index  in  PHT_INDEX_BITS  index from pred_index
- update_ghr  in  GHR_BITS  checkpoint from pred_ghr
- update_taken  in  1  actual outcome
- update_mispredict  in  1  predicted direction was wrong
- mispredict_count  out  PERF_BITS  saturating count of mispredicts

Behaviour:
- Reset (reset=0, asynchronous, effective immediately):
  - all PHT counters = CTR_INIT; GHR = 0; mispredict_count = 0.
  - Resulting outputs: pred_ghr = 0; pred_index = lookup_pc index bits; pred_taken = MSB of CTR_INIT (0 for the default).
  - Reset mid-operation discards all history and training; updates in flight are lost.
- Index: pred_index = lookup_pc[PC_LSB+PHT_INDEX_BITS-1:PC_LSB] XOR {zeros, GHR}, with GHR zero-extended to PHT_INDEX_BITS.
- Prediction is combinational, same cycle (0 latency):
  - lookup_is_uncond=1 -> pred_taken = 1.
  - Otherwise pred_taken = MSB of PHT[pred_index].
  - pred_ghr = current GHR. Outputs are don't-care when lookup_valid=0.
- Speculative GHR update at the clock edge:
  - lookup_valid & lookup_is_cond & !lookup_is_uncond -> GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
  - Unconditional branches and non-branches leave GHR unchanged. is_cond and is_uncond both set -> treated as unconditional.
  - GHR_BITS=1 -> GHR <= pred_taken.
- PHT update at the clock edge when update_valid=1:
  - update_taken=1 -> PHT[update_index] increments, saturating at 2^CTR_BITS-1.
  - update_taken=0 -> decrements, saturating at 0.
  - Applies regardless of update_mispredict.
- Recovery: update_valid & update_mispredict -> GHR <= {update_ghr[GHR_BITS-2:0], update_taken}, overriding any speculative shift in the same cycle (the younger lookup is squashed by fetch).
- mispredict_count increments on update_valid & update_mispredict and saturates at all-ones (no wrap).
- Same-cycle lookup and update to the same index: the lookup sees the pre-update counter (no bypass); the counter write still occurs.
- update_valid=0 -> update_* ignored; update_mispredict without update_valid is ignored.
- One lookup and one update per cycle; no backpressure, always ready.

Test Plan (defaults):
- Async reset: drive reset=0 mid-cycle after training -> immediately mispredict_count=0, pred_ghr=0. Then lookup_pc=0x00000124 cond -> pred_index=0x09, pred_taken=0.
- Training/saturation: 2x update index 0x09 taken -> lookup pc 0x124 (GHR 0) gives pred_taken=1. 2 more taken updates, then 2 not-taken -> counter 11->10->01, pred_taken=0. 2 further not-taken -> counter stays 00, no wrap.
- Speculative history: with PHT[0x09]=11, cond lookup pc 0x124 -> next cycle pred_ghr=000001. Cond lookup of pc 0x100 (index 0x01, counter 01) -> then GHR=000010.
- Unconditional: lookup_is_uncond=1, pc 0x200 -> pred_taken=1, GHR unchanged next cycle.
- Recovery priority: same cycle, cond lookup predicting taken plus update_valid, update_mispredict=1, update_ghr=101010, update_taken=1 -> GHR=010101, mispredict_count +1.
- Perf saturation: force 65536 mispredict updates -> mispredict_count holds 0xFFFF.
